// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, fetch FSM state and instruction field helpers.
package cpu_pkg;

    localparam logic [5:0] OPC_J = 6'h02;

    typedef enum logic {FETCH, FAULT} fetch_state_t;

    function automatic logic [5:0] opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [25:0] target(input logic [31:0] instr);
        return instr[25:0];
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: sequential/J-type next-PC selection plus alignment and range check of the current PC.
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 36
) (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        bad_pc
);

    localparam logic [31:0] MAX_PC = 32'(IMEM_BYTES - 4);

    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = (opcode(instr) == OPC_J) ? {pc_plus4[31:28], target(instr), 2'b00} : pc_plus4;
        bad_pc   = (pc[1:0] != 2'b00) || (pc > MAX_PC);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches from instruction memory and fills the IF/ID register.
// A bad PC drops the unit into a sticky FAULT state that only reset leaves.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned IMEM_BYTES = 36
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fault,
    output logic [31:0] fault_pc
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_plus4, next_pc;
    logic         bad_pc, redir, flt, adv;

    fetch_next_pc #(.IMEM_BYTES(IMEM_BYTES)) u_next (
        .pc       (pc),
        .instr    (imem_instr),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc),
        .bad_pc   (bad_pc)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_d;
    end

    always_comb begin
        state_d = (state == FETCH && !redirect_valid && bad_pc) ? FAULT : state;
    end

    // A redirect wins over everything, so a fault on a wrong-path PC never fires.
    always_comb begin
        redir = (state == FETCH) && redirect_valid;
        flt   = (state == FETCH) && !redirect_valid && bad_pc;
        adv   = (state == FETCH) && !redirect_valid && !bad_pc && !stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            fault          <= 1'b0;
            fault_pc       <= 32'h0;
        end else if (redir) begin
            pc          <= redirect_pc;
            if_id_instr <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (flt) begin
            fault       <= 1'b1;
            fault_pc    <= pc;
            if_id_valid <= 1'b0;
        end else if (adv) begin
            pc             <= next_pc;
            if_id_instr    <= imem_instr;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench; expected IF/ID words are queued by stimulus and popped by a monitor.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } exp_t;

    logic        clk = 0;
    logic        reset, stall, redirect_valid;
    logic [31:0] redirect_pc, imem_addr, imem_instr;
    logic [31:0] if_id_instr, if_id_pc_plus4, fault_pc;
    logic        if_id_valid, fault;
    logic [31:0] mem [0:15];
    exp_t        sb [$];
    int          checks = 0, errors = 0;
    logic        held = 1'b1;

    instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(36)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd36 && imem_addr[1:0] == 2'b00) ? mem[imem_addr[5:2]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc4);
        sb.push_back('{instr: instr, pc_plus4: pc4});
    endtask

    // A held IF/ID (stall or reset at the last edge) is not a new instruction.
    always @(posedge clk) held = stall || reset;

    always @(negedge clk) begin
        if (if_id_valid && !held) begin
            if (sb.size() == 0) chk("unexpected_valid", if_id_instr, 32'hxxxxxxxx);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", if_id_instr, e.instr);
                chk("sb_pc_plus4", if_id_pc_plus4, e.pc_plus4);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h8C41000A; mem[1] = 32'hAC610005; mem[2] = 32'h00A31025;
        mem[3] = 32'h00C70825; mem[4] = 32'h3061000A; mem[5] = 32'h08000001;
        reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        step; step;
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        reset = 0;
        expect_word(32'h8C41000A, 32'd4);  expect_word(32'hAC610005, 32'd8);
        expect_word(32'h00A31025, 32'd12); expect_word(32'h00C70825, 32'd16);
        expect_word(32'h3061000A, 32'd20); expect_word(32'h08000001, 32'h18);
        repeat (6) step;
        chk("jump_addr", imem_addr, 32'h4);
        expect_word(32'hAC610005, 32'd8);  expect_word(32'h00A31025, 32'd12);
        step; step;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step;
            @(negedge clk);
            chk("stall_instr", if_id_instr, 32'h00A31025);
            chk("stall_addr", imem_addr, 32'hC);
            chk("stall_valid", {31'h0, if_id_valid}, 32'h1);
        end
        #1 stall = 0;
        expect_word(32'h00C70825, 32'd16);
        step;
        redirect_valid = 1; redirect_pc = 32'h10; stall = 1;
        step;
        redirect_valid = 0; stall = 0;
        @(negedge clk);
        chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h10);
        expect_word(32'h3061000A, 32'h14);
        step;
        redirect_valid = 1; redirect_pc = 32'h6;
        step;
        redirect_valid = 0;
        step;
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_fault_pc", fault_pc, 32'h6);
        chk("mis_valid", {31'h0, if_id_valid}, 32'h0);
        redirect_valid = 1; redirect_pc = 32'h0;
        step;
        redirect_valid = 0;
        chk("fault_ignore_redir", imem_addr, 32'h6);
        chk("fault_sticky", {31'h0, fault}, 32'h1);
        reset = 1;
        step;
        reset = 0;
        chk("rst2_fault", {31'h0, fault}, 32'h0);
        chk("rst2_addr", imem_addr, 32'h0);
        mem[5] = 32'h0;
        expect_word(32'h8C41000A, 32'd4);  expect_word(32'hAC610005, 32'd8);
        expect_word(32'h00A31025, 32'd12); expect_word(32'h00C70825, 32'd16);
        expect_word(32'h3061000A, 32'd20); expect_word(32'h0, 32'd24);
        expect_word(32'h0, 32'd28);        expect_word(32'h0, 32'd32);
        expect_word(32'h0, 32'd36);
        repeat (9) step;
        chk("range_addr_pre", imem_addr, 32'd36);
        step;
        chk("range_fault", {31'h0, fault}, 32'h1);
        chk("range_fault_pc", fault_pc, 32'd36);
        step; step;
        chk("range_pc_frozen", imem_addr, 32'd36);
        chk("range_valid", {31'h0, if_id_valid}, 32'h0);
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
